pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall, flush and redirect sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It combines four inputs into per-stage register enables and bubble/flush controls: the multiplier stall and branch/jump resolution from the execute stage, a load-use hazard detected against ID, and the memory-stage stall. It also owns the PC redirect, holding a resolved jump target while a higher-priority hazard blocks it.

## Interface
- No parameters.
- sys_clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on sys_clk rising edge
- id_rs, id_rt  in  5 each  source register ids of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_stall  in  1  execute multiplier busy
- ex_do_jump  in  1  EX instruction redirects control flow
- ex_j_addr  in  32  redirect target from EX
- mem_stall  in  1  memory access not complete
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each  load NOP into that register
- pc_redirect  out  1  PC loads pc_target instead of PC+4 (qualified by pc_en)
- pc_target  out  32  redirect address
- ctrl_state  out  2  FSM state: 0 RUN, 1 EX_WAIT, 2 MEM_WAIT, 3 REDIR_PEND

## Operation
- load_use = ex_is_load && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
- Resolution is evaluated each cycle in priority order. The first true condition sets the controls; every other output is at its default. Defaults: all *_en=1, all flush/bubble=0, pc_redirect=0.
  1. mem_stall
     - All five enables are 0 and mem_wb_bubble=1 (WB must not repeat a write).
     - ex_do_jump is ignored; EX holds the jump and re-resolves it later.
  2. ex_stall
     - pc_en, if_id_en and id_ex_en are 0.
     - ex_mem_bubble=1; mem_wb_en=1, so older instructions drain.
  3. load_use
     - pc_en and if_id_en are 0; id_ex_bubble=1.
     - EX and later stages advance.
     - If ex_do_jump=1 in the same cycle, capture ex_j_addr into pend_addr and set pend.
  4. pend set
     - pc_redirect=1, pc_target=pend_addr, if_id_flush=1.
     - pend is cleared.
  5. ex_do_jump
     - pc_redirect=1, pc_target=ex_j_addr, if_id_flush=1.
     - ID (delay slot) advances normally.
- A new ex_do_jump while pend is set is impossible by construction. This is a verification assertion, not handled.
- pc_target = pend ? pend_addr : ex_j_addr. It is don't-care when pc_redirect=0 and is driven 0 then.
- FSM next state:
  - MEM_WAIT if mem_stall.
  - else EX_WAIT if ex_stall.
  - else REDIR_PEND if pend will be set after this edge.
  - else RUN.
- ctrl_state is diagnostic only; it does not feed back into output logic except through pend.

## Timing
- All controls are combinational from the current inputs plus the pend/pend_addr registers, so they take effect in the same cycle.
- pend, pend_addr, FSM and counters update on the rising edge.
- Load-use costs exactly 1 bubble.
- A redirect delayed by load-use issues on the first cycle with no mem_stall, no ex_stall and no load_use, at least 1 cycle later.
- ex_stall for N cycles gives N EX/MEM bubbles; the multiplier result enters EX/MEM on the first cycle with ex_stall=0.
- Reset (rst_n=0 at an edge):
  - After the edge: pend=0, pend_addr=0, state RUN, counters 0.
  - While rst_n=0: all *_en=0, if_id_flush=1, all bubbles=1, pc_redirect=0, pc_target=0.
  - A reset during an active stall or pend discards it.
- Simultaneous mem_stall and ex_stall resolve as mem_stall. On release of mem_stall, ex_stall (if still asserted) takes effect in that same cycle.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cycles (32, counts cycles with any of rule 1–3 active) and perf_flush_count (32, counts cycles with if_id_flush=1 outside reset).
  - Both wrap at 2^32 and reset to 0.
- Undefined: the outputs and counters are absent; behaviour is otherwise identical.

## Test plan
- lw $t0 in EX, ID reads rs=$t0 (8) -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; the next cycle is all defaults.
- ex_stall high 3 cycles -> pc_en/if_id_en/id_ex_en=0 and ex_mem_bubble=1 for exactly 3 cycles, mem_wb_en=1 throughout.
- ex_do_jump=1, ex_j_addr=0x0040_0100, no hazards -> same cycle pc_redirect=1, pc_target=0x0040_0100, if_id_flush=1, id_ex_en=1.
- load_use and ex_do_jump (target 0x0040_0200) together -> cycle 0: pc_redirect=0, ctrl_state becomes 3. Cycle 1 (hazard gone): pc_redirect=1, pc_target=0x0040_0200, if_id_flush=1; then state 0.
- mem_stall together with ex_stall and ex_do_jump for 2 cycles -> all enables 0, mem_wb_bubble=1, no redirect, pend stays 0, ctrl_state=2.
- rst_n=0 while state=REDIR_PEND -> after the edge pend=0, state 0, and no redirect issued once rst_n=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencer for the 5-stage pipeline; PIPE_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic        ex_stall,
   input  logic        ex_do_jump,
   input  logic [31:0] ex_j_addr,
   input  logic        mem_stall,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        ex_mem_bubble,
   output logic        mem_wb_bubble,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic [1:0]  ctrl_state
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);
   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] EX_WAIT    = 2'd1;
   localparam logic [1:0] MEM_WAIT   = 2'd2;
   localparam logic [1:0] REDIR_PEND = 2'd3;

   logic        load_use;
   logic        pend;
   logic        pend_nx;
   logic [31:0] pend_addr;

   assign load_use = ex_is_load && ex_rd != 5'd0 &&
                     ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

   // a pending redirect survives stalls, is created by a jump blocked by load-use, and issues otherwise
   assign pend_nx = (mem_stall || ex_stall) ? pend : load_use ? (pend || ex_do_jump) : 1'b0;

   // priority resolution of the hazard sources into per-stage controls
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;
      pc_redirect   = 1'b0;
      pc_target     = 32'd0;
      if (!rst_n) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_en     = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (mem_stall) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_en     = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (ex_stall) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_bubble = 1'b1;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (pend || ex_do_jump) begin
         pc_redirect = 1'b1;
         if_id_flush = 1'b1;
         pc_target   = pend ? pend_addr : ex_j_addr;
      end
   end

   // pending redirect register and diagnostic state
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         pend_addr  <= 32'd0;
         ctrl_state <= RUN;
      end else begin
         pend       <= pend_nx;
         if (!mem_stall && !ex_stall && load_use && ex_do_jump && !pend)
            pend_addr <= ex_j_addr;
         ctrl_state <= mem_stall ? MEM_WAIT : ex_stall ? EX_WAIT : pend_nx ? REDIR_PEND : RUN;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // stall-cycle and flush counters, wrapping at 2^32
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         perf_stall_cycles <= 32'd0;
         perf_flush_count  <= 32'd0;
      end else begin
         if (mem_stall || ex_stall || load_use)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (if_id_flush)
            perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a stage-freeze model
module tb_pipe_hazard_ctrl;
   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_use_rs, id_use_rt, ex_is_load, ex_stall, ex_do_jump, mem_stall;
   logic [31:0] ex_j_addr;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, pc_redirect;
   logic [31:0] pc_target;
   logic [1:0]  ctrl_state;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

   int n_chk = 0;
   int n_fail = 0;

   logic        known = 1'b0;
   logic        pend_m = 1'b0, pend_n;
   logic [31:0] paddr_m = 0, paddr_n;
   logic [1:0]  state_m = 0, state_n;
   logic [31:0] stall_m = 0, stall_n, flush_m = 0, flush_n;

   pipe_hazard_ctrl dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_stall(ex_stall),
      .ex_do_jump(ex_do_jump), .ex_j_addr(ex_j_addr), .mem_stall(mem_stall),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .ctrl_state(ctrl_state)
`ifdef PIPE_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0;
      ex_is_load = 0; ex_stall = 0; ex_do_jump = 0; mem_stall = 0; ex_j_addr = 0;
   endtask

   // model: hazards freeze a prefix of the register chain {pc,if_id,id_ex,ex_mem,mem_wb}
   // and inject a NOP into the first register after the frozen prefix
   task automatic eval();
      int f;
      logic lu, redir;
      logic [4:0] en;
      logic [2:0] bub;
      logic [9:0] e, a;
      logic [31:0] t;
      #2;
      lu = ex_is_load && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      f = !rst_n ? -1 : mem_stall ? 5 : ex_stall ? 3 : lu ? 2 : 0;
      redir = (f == 0) && (pend_m || ex_do_jump);
      t = redir ? (pend_m ? paddr_m : ex_j_addr) : 32'd0;
      if (f < 0) e = 10'b00000_1_111_0;
      else begin
         for (int i = 0; i < 5; i++) en[i] = (i >= f);
         bub = 3'b000;
         if (f > 0) bub[(f == 5 ? 4 : f) - 2] = 1'b1;
         e = {en[0], en[1], en[2], en[3], en[4], redir, bub[0], bub[1], bub[2], redir};
      end
      a = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, ex_mem_bubble, mem_wb_bubble, pc_redirect};
      chk("controls", {22'd0, a}, {22'd0, e});
      chk("pc_target", pc_target, t);
      if (known) chk("ctrl_state", {30'd0, ctrl_state}, {30'd0, state_m});
`ifdef PIPE_PERF_CNT_EN
      if (known) begin
         chk("perf_stall", perf_stall_cycles, stall_m);
         chk("perf_flush", perf_flush_count, flush_m);
      end
`endif
      pend_n = pend_m; paddr_n = paddr_m;
      if (f == 2 && ex_do_jump && !pend_m) begin pend_n = 1'b1; paddr_n = ex_j_addr; end
      else if (f == 0) pend_n = 1'b0;
      state_n = f == 5 ? 2'd2 : f == 3 ? 2'd1 : pend_n ? 2'd3 : 2'd0;
      stall_n = stall_m + ((f > 0) ? 32'd1 : 32'd0);
      flush_n = flush_m + (redir ? 32'd1 : 32'd0);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      if (!rst_n) begin
         known = 1'b1; pend_m = 0; paddr_m = 0; state_m = 0; stall_m = 0; flush_m = 0;
      end else begin
         pend_m = pend_n; paddr_m = paddr_n; state_m = state_n; stall_m = stall_n; flush_m = flush_n;
      end
      @(negedge sys_clk);
   endtask

   initial begin
      idle(); rst_n = 1'b0;
      @(negedge sys_clk);
      // reset outputs
      eval();
      chk("rst pc_en", {31'd0, pc_en}, 32'd0);
      chk("rst flush", {31'd0, if_id_flush}, 32'd1);
      chk("rst mem_wb_bubble", {31'd0, mem_wb_bubble}, 32'd1);
      chk("rst pc_target", pc_target, 32'd0);
      tick();
      idle(); eval();
      chk("post-rst state", {30'd0, ctrl_state}, 32'd0);
      tick();
      // load-use costs one bubble
      ex_is_load = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1; eval();
      chk("lu pc_en", {31'd0, pc_en}, 32'd0);
      chk("lu if_id_en", {31'd0, if_id_en}, 32'd0);
      chk("lu id_ex_bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick(); idle(); eval();
      chk("lu next pc_en", {31'd0, pc_en}, 32'd1);
      chk("lu next bubble", {31'd0, id_ex_bubble}, 32'd0);
      tick();
      // multiplier stall for three cycles
      for (int i = 0; i < 3; i++) begin
         ex_stall = 1; eval();
         chk("exs ex_mem_bubble", {31'd0, ex_mem_bubble}, 32'd1);
         chk("exs id_ex_en", {31'd0, id_ex_en}, 32'd0);
         chk("exs mem_wb_en", {31'd0, mem_wb_en}, 32'd1);
         tick();
      end
      idle(); eval();
      chk("exs release bubble", {31'd0, ex_mem_bubble}, 32'd0);
      tick();
      // unobstructed jump
      ex_do_jump = 1; ex_j_addr = 32'h0040_0100; eval();
      chk("jmp redirect", {31'd0, pc_redirect}, 32'd1);
      chk("jmp target", pc_target, 32'h0040_0100);
      chk("jmp flush", {31'd0, if_id_flush}, 32'd1);
      chk("jmp id_ex_en", {31'd0, id_ex_en}, 32'd1);
      tick();
      // jump blocked by load-use becomes pending
      idle(); ex_is_load = 1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1;
      ex_do_jump = 1; ex_j_addr = 32'h0040_0200; eval();
      chk("pend c0 redirect", {31'd0, pc_redirect}, 32'd0);
      tick(); idle(); eval();
      chk("pend c1 state", {30'd0, ctrl_state}, 32'd3);
      chk("pend c1 redirect", {31'd0, pc_redirect}, 32'd1);
      chk("pend c1 target", pc_target, 32'h0040_0200);
      chk("pend c1 flush", {31'd0, if_id_flush}, 32'd1);
      tick(); eval();
      chk("pend c2 state", {30'd0, ctrl_state}, 32'd0);
      chk("pend c2 redirect", {31'd0, pc_redirect}, 32'd0);
      tick();
      // mem_stall dominates ex_stall and jump
      for (int i = 0; i < 2; i++) begin
         mem_stall = 1; ex_stall = 1; ex_do_jump = 1; ex_j_addr = 32'h0040_0300; eval();
         chk("ms mem_wb_en", {31'd0, mem_wb_en}, 32'd0);
         chk("ms mem_wb_bubble", {31'd0, mem_wb_bubble}, 32'd1);
         chk("ms redirect", {31'd0, pc_redirect}, 32'd0);
         tick();
      end
      idle(); eval();
      chk("ms state", {30'd0, ctrl_state}, 32'd2);
      chk("ms no pend", {31'd0, pc_redirect}, 32'd0);
      tick();
      // reset discards a pending redirect
      ex_is_load = 1; ex_rd = 5'd4; id_rs = 5'd4; id_use_rs = 1;
      ex_do_jump = 1; ex_j_addr = 32'h0040_0400; eval();
      tick(); idle(); rst_n = 0; eval();
      chk("rp state", {30'd0, ctrl_state}, 32'd3);
      tick(); idle(); eval();
      chk("rp redirect", {31'd0, pc_redirect}, 32'd0);
      chk("rp state after", {30'd0, ctrl_state}, 32'd0);
      tick();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n      = $urandom_range(0, 39) != 0;
         mem_stall  = $urandom_range(0, 5) == 0;
         ex_stall   = $urandom_range(0, 4) == 0;
         ex_is_load = $urandom_range(0, 1) == 1;
         ex_rd      = 5'($urandom_range(0, 3));
         id_rs      = 5'($urandom_range(0, 3));
         id_rt      = 5'($urandom_range(0, 3));
         id_use_rs  = $urandom_range(0, 1) == 1;
         id_use_rt  = $urandom_range(0, 1) == 1;
         ex_do_jump = !pend_m && $urandom_range(0, 3) == 0;
         ex_j_addr  = $urandom;
         eval();
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
